// File: rtl/param_stack.sv
// Purpose: parametrised LIFO of {flag, data} pairs saving and restoring CPU operand/flag context.
// Latency: show-ahead; a pushed entry is visible on data_out/flag_out right after the pushing edge.
// Backpressure: none; rejected pushes/pops are dropped and flagged by one-cycle ovf/udf pulses.
//
// Ports:
//   CLK               clock, all state updates on the rising edge
//   RESET             synchronous active-low reset (count/ovf/udf/hwm cleared, storage kept)
//   push, pop         operation requests; both together replace the top entry
//   data_in, flag_in  entry to push
//   data_out,flag_out top-of-stack entry, zero when empty
//   empty, full       combinational decodes of count
//   count             number of valid entries
//   ovf, udf          registered one-cycle error pulses (push when full / pop when empty)
//   hwm, hwm_clr      high-water mark and its clear, present only with PARAM_STACK_HWM_EN
//
// Optional feature macro: PARAM_STACK_HWM_EN
module param_stack #(
    parameter int DATA_W = 16,
    parameter int FLAG_W = 4,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] data_in,
    input  logic [FLAG_W-1:0] flag_in,
    output logic [DATA_W-1:0] data_out,
    output logic [FLAG_W-1:0] flag_out,
    output logic              empty,
    output logic              full,
    output logic [CNT_W-1:0]  count,
    output logic              ovf,
    output logic              udf
`ifdef PARAM_STACK_HWM_EN
    ,
    output logic [CNT_W-1:0]  hwm,
    input  logic              hwm_clr
`endif
);

    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WORD_W = FLAG_W + DATA_W;

    logic [WORD_W-1:0] mem [DEPTH];

    logic [CNT_W-1:0]  count_nxt;
    logic              ovf_nxt;
    logic              udf_nxt;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] push_addr;
    logic [ADDR_W-1:0] top_addr;
    logic [WORD_W-1:0] top_word;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

    // Addresses are only used when in range (push_addr when not full,
    // top_addr when not empty), so truncating count is safe.
    assign push_addr = ADDR_W'(count);
    assign top_addr  = ADDR_W'(count - CNT_W'(1));

    always_comb begin
        count_nxt = count;
        ovf_nxt   = 1'b0;
        udf_nxt   = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = push_addr;
        case ({push, pop})
            2'b10: begin
                if (!full) begin
                    wr_en     = 1'b1;
                    count_nxt = count + CNT_W'(1);
                end else begin
                    ovf_nxt = 1'b1;
                end
            end
            2'b01: begin
                if (!empty) begin
                    count_nxt = count - CNT_W'(1);
                end else begin
                    udf_nxt = 1'b1;
                end
            end
            2'b11: begin
                wr_en = 1'b1;
                if (empty) begin
                    // Nothing to replace: behaves as a plain push into slot 0.
                    count_nxt = CNT_W'(1);
                end else begin
                    wr_addr = top_addr;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            count <= '0;
            ovf   <= 1'b0;
            udf   <= 1'b0;
        end else begin
            count <= count_nxt;
            ovf   <= ovf_nxt;
            udf   <= udf_nxt;
        end
    end

    // Storage is deliberately not cleared by reset; reset only blocks writes.
    always_ff @(posedge CLK) begin
        if (RESET && wr_en) begin
            mem[wr_addr] <= {flag_in, data_in};
        end
    end

    assign top_word = mem[top_addr];
    assign data_out = empty ? '0 : top_word[DATA_W-1:0];
    assign flag_out = empty ? '0 : top_word[DATA_W +: FLAG_W];

`ifdef PARAM_STACK_HWM_EN
    logic [CNT_W-1:0] hwm_nxt;

    always_comb begin
        hwm_nxt = hwm;
        if (hwm_clr) begin
            hwm_nxt = count_nxt;
        end else if (count_nxt > hwm) begin
            hwm_nxt = count_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            hwm <= '0;
        end else begin
            hwm <= hwm_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_param_stack.sv
// Purpose: directed self-checking bench for param_stack (DEPTH=8, DATA_W=8, FLAG_W=4).
// Latency: inputs driven 1 time unit after a rising edge, outputs sampled 1 unit after the next.
// Backpressure: not applicable; the bench drives one operation per cycle.
module tb_param_stack;

    localparam int DATA_W = 8;
    localparam int FLAG_W = 4;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              CLK;
    logic              RESET;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] data_in;
    logic [FLAG_W-1:0] flag_in;
    logic [DATA_W-1:0] data_out;
    logic [FLAG_W-1:0] flag_out;
    logic              empty;
    logic              full;
    logic [CNT_W-1:0]  count;
    logic              ovf;
    logic              udf;
`ifdef PARAM_STACK_HWM_EN
    logic [CNT_W-1:0]  hwm;
    logic              hwm_clr;
`endif

    int n_chk = 0;
    int n_bad = 0;

    param_stack #(
        .DATA_W(DATA_W),
        .FLAG_W(FLAG_W),
        .DEPTH (DEPTH)
    ) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .push    (push),
        .pop     (pop),
        .data_in (data_in),
        .flag_in (flag_in),
        .data_out(data_out),
        .flag_out(flag_out),
        .empty   (empty),
        .full    (full),
        .count   (count),
        .ovf     (ovf),
`ifdef PARAM_STACK_HWM_EN
        .hwm     (hwm),
        .hwm_clr (hwm_clr),
`endif
        .udf     (udf)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock edge with the given operation, then sample point.
    task automatic cyc(input logic p, input logic q, input logic [DATA_W-1:0] d,
                       input logic [FLAG_W-1:0] f);
        push    = p;
        pop     = q;
        data_in = d;
        flag_in = f;
        @(posedge CLK);
        #1;
        push    = 1'b0;
        pop     = 1'b0;
    endtask

    task automatic do_reset(input logic p);
        RESET = 1'b0;
        cyc(p, 1'b0, 8'hEE, 4'hE);
        RESET = 1'b1;
    endtask

    initial begin
        RESET   = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        data_in = '0;
        flag_in = '0;
`ifdef PARAM_STACK_HWM_EN
        hwm_clr = 1'b0;
`endif
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RESET = 1'b1;

        // Reset state
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_udf", udf, 0);
        chk("rst_data", data_out, 0);
        chk("rst_flag", flag_out, 0);

        // Basic LIFO order
        cyc(1, 0, 8'h11, 4'h1);
        chk("p1_top", data_out, 8'h11);
        cyc(1, 0, 8'h22, 4'h2);
        cyc(1, 0, 8'h33, 4'h3);
        chk("p3_count", count, 3);
        chk("p3_data", data_out, 8'h33);
        chk("p3_flag", flag_out, 4'h3);
        chk("pop1_val", data_out, 8'h33);
        cyc(0, 1, 0, 0);
        chk("pop2_val", data_out, 8'h22);
        chk("pop2_flag", flag_out, 4'h2);
        cyc(0, 1, 0, 0);
        chk("pop3_val", data_out, 8'h11);
        cyc(0, 1, 0, 0);
        chk("pop_empty", empty, 1);
        chk("pop_count", count, 0);
        chk("pop_data0", data_out, 0);
        chk("pop_flag0", flag_out, 0);

        // Fill and overflow
        for (int i = 0; i < DEPTH; i++) begin
            chk("fill_full_lo", full, 0);
            cyc(1, 0, 8'hA0 + 8'(i), 4'(i));
        end
        chk("fill_full", full, 1);
        chk("fill_count", count, 8);
        chk("fill_top", data_out, 8'hA7);
        chk("fill_ovf0", ovf, 0);
        cyc(1, 0, 8'hFF, 4'hF);
        chk("ovf_pulse", ovf, 1);
        chk("ovf_count", count, 8);
        chk("ovf_top", data_out, 8'hA7);
        chk("ovf_flag", flag_out, 4'h7);
        cyc(0, 0, 0, 0);
        chk("ovf_clear", ovf, 0);
        chk("ovf_top2", data_out, 8'hA7);

        // Underflow, then push+pop on empty
        do_reset(0);
        cyc(0, 1, 0, 0);
        chk("udf_pulse", udf, 1);
        chk("udf_count", count, 0);
        cyc(0, 0, 0, 0);
        chk("udf_clear", udf, 0);
        cyc(1, 1, 8'h5A, 4'h5);
        chk("pp_empty_count", count, 1);
        chk("pp_empty_data", data_out, 8'h5A);
        chk("pp_empty_flag", flag_out, 4'h5);
        chk("pp_empty_udf", udf, 0);

        // Replace top with 3 entries
        do_reset(0);
        cyc(1, 0, 8'h11, 4'h1);
        cyc(1, 0, 8'h22, 4'h2);
        cyc(1, 0, 8'h33, 4'h3);
        cyc(1, 1, 8'h77, 4'h7);
        chk("rep_count", count, 3);
        chk("rep_data", data_out, 8'h77);
        chk("rep_flag", flag_out, 4'h7);
        chk("rep_ovf", ovf, 0);
        chk("rep_udf", udf, 0);
        cyc(0, 1, 0, 0);
        chk("rep_pop", data_out, 8'h22);
        chk("rep_pop_cnt", count, 2);

        // Replace top when full
        for (int i = 0; i < 6; i++) cyc(1, 0, 8'hB0 + 8'(i), 4'(i));
        chk("rf_full", full, 1);
        chk("rf_top", data_out, 8'hB5);
        cyc(1, 1, 8'hCC, 4'hC);
        chk("rf_count", count, 8);
        chk("rf_ovf", ovf, 0);
        chk("rf_data", data_out, 8'hCC);
        chk("rf_flag", flag_out, 4'hC);
        cyc(0, 1, 0, 0);
        chk("rf_pop", data_out, 8'hB4);

        // Reset mid-sequence with push asserted
        do_reset(0);
        for (int i = 0; i < 5; i++) cyc(1, 0, 8'h40 + 8'(i), 4'(i));
        chk("mr_pre", count, 5);
        do_reset(1);
        chk("mr_count", count, 0);
        chk("mr_empty", empty, 1);
        chk("mr_ovf", ovf, 0);
        chk("mr_udf", udf, 0);
        chk("mr_data", data_out, 0);

        // Reset while full and pushing: no ovf may appear
        for (int i = 0; i < DEPTH; i++) cyc(1, 0, 8'h60 + 8'(i), 4'(i));
        do_reset(1);
        chk("fr_ovf", ovf, 0);
        chk("fr_count", count, 0);

        // Reset pulse between edges is ignored
        cyc(1, 0, 8'h81, 4'h1);
        cyc(1, 0, 8'h82, 4'h2);
        #2 RESET = 1'b0;
        #2 RESET = 1'b1;
        cyc(0, 0, 0, 0);
        chk("glitch_count", count, 2);
        chk("glitch_data", data_out, 8'h82);

`ifdef PARAM_STACK_HWM_EN
        do_reset(0);
        chk("hwm_rst", hwm, 0);
        for (int i = 0; i < 6; i++) cyc(1, 0, 8'(i), 4'(i));
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0);
        chk("hwm_peak", hwm, 6);
        chk("hwm_cnt", count, 2);
        hwm_clr = 1'b1;
        cyc(0, 0, 0, 0);
        hwm_clr = 1'b0;
        chk("hwm_clr", hwm, 2);
        cyc(1, 0, 8'h99, 4'h9);
        chk("hwm_push", hwm, 3);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
